regop_seq: RTL

Sequencer for the 8x16 register file with two combinational read ports and one write port. It accepts one register-to-register instruction at a time (opcode, source register, destination register) over a valid/ready handshake. It drives the register file selects and write enable, computes the result in an internal 16-bit ALU, and updates the condition codes. It then advances PC (R7) by PC_STEP. It sits between the instruction decoder and the register file, as the sole owner of the register file control signals.

---
 rtl/regop_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regop_seq.sv
// Register-to-register instruction sequencer: owns the 8x16 register file
// controls, runs a 16-bit ALU, keeps {N,Z,V,C} and advances PC after each op.
module regop_seq #(
  parameter int unsigned PC_STEP = 2,
  parameter int unsigned PC_REG  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_src,
  input  logic [2:0]  in_dst,
  output logic [2:0]  rf_sela,
  output logic [2:0]  rf_selb,
  output logic        rf_we,
  output logic [15:0] rf_w,
  input  logic [15:0] rf_a,
  input  logic [15:0] rf_b,
  output logic [3:0]  cc,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, EXEC, PCINC} state_e;
  typedef enum logic [2:0] {
    OP_MOV = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_CMP = 3'b011,
    OP_BIC = 3'b100, OP_BIS = 3'b101, OP_INC = 3'b110, OP_CLR = 3'b111
  } op_e;

  localparam logic [2:0]  PC_IDX = 3'(PC_REG);
  localparam logic [15:0] STEP   = 16'(PC_STEP);

  state_e      state, state_nx;
  op_e         op_q;
  logic [2:0]  src_q, dst_q;
  logic [15:0] res;
  logic [3:0]  cc_nx;
  logic [16:0] sum17, dif17;
  logic        writes, jump;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_MOV;
      src_q <= '0;
      dst_q <= '0;
      cc    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        op_q  <= op_e'(in_op);
        src_q <= in_src;
        dst_q <= in_dst;
      end
      if (state == EXEC) cc <= cc_nx;
    end
  end

  // ALU: S = rf_a, D = rf_b; flags not named by an op keep their old value.
  always_comb begin
    sum17 = {1'b0, rf_b} + {1'b0, rf_a};
    dif17 = {1'b0, rf_b} - {1'b0, rf_a};
    res   = '0;
    cc_nx = cc;
    case (op_q)
      OP_MOV: begin res = rf_a;          cc_nx[1] = 1'b0; end
      OP_ADD: begin
        res      = sum17[15:0];
        cc_nx[0] = sum17[16];
        cc_nx[1] = (rf_a[15] == rf_b[15]) && (res[15] != rf_b[15]);
      end
      OP_SUB, OP_CMP: begin
        res      = dif17[15:0];
        cc_nx[0] = dif17[16];
        cc_nx[1] = (rf_a[15] != rf_b[15]) && (res[15] == rf_a[15]);
      end
      OP_BIC: begin res = rf_b & ~rf_a;  cc_nx[1] = 1'b0; end
      OP_BIS: begin res = rf_b | rf_a;   cc_nx[1] = 1'b0; end
      OP_INC: begin
        res      = rf_b + 16'd1;
        cc_nx[1] = (rf_b == 16'o077777);
      end
      OP_CLR: begin res = '0; cc_nx[1] = 1'b0; cc_nx[0] = 1'b0; end
      default: res = '0;
    endcase
    cc_nx[3] = res[15];
    cc_nx[2] = (res == '0);
  end

  assign writes = (op_q != OP_CMP);
  assign jump   = writes && (dst_q == PC_IDX);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = EXEC;
      EXEC:    state_nx = jump ? IDLE : PCINC;
      PCINC:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    rf_sela  = '0;
    rf_selb  = '0;
    rf_we    = 1'b0;
    rf_w     = '0;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      IDLE: in_ready = ~reset;
      EXEC: begin
        rf_sela = src_q;
        rf_selb = dst_q;
        rf_we   = writes;
        rf_w    = res;
        done    = jump;
      end
      PCINC: begin
        rf_selb = PC_IDX;
        rf_we   = 1'b1;
        rf_w    = rf_b + STEP;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
